// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // A beat counter needs at least one bit, even for single-beat bursts.
  function automatic int beat_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry register skid buffer: head register feeds the stream, tail absorbs one extra word.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [P_DATA_WIDTH-1:0] wdata_i,
  output logic [P_DATA_WIDTH-1:0] head_o,
  output occ_t                    occ_o
);

  logic [P_DATA_WIDTH-1:0] head_q, head_d;
  logic [P_DATA_WIDTH-1:0] tail_q, tail_d;
  occ_t                    occ_q, occ_d;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == occ_t'(0)) begin
          head_d = wdata_i;
          occ_d  = occ_t'(1);
        end else if (occ_q == occ_t'(1)) begin
          tail_d = wdata_i;
          occ_d  = occ_t'(SKID_DEPTH);
        end
        // A push into a full buffer is dropped; only a protocol violation gets here.
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - occ_t'(1);
      end
      2'b11: begin
        if (occ_q == occ_t'(1)) begin
          head_d = wdata_i;
        end else begin
          head_d = tail_q;
          tail_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the two data registers are reset too, so m_data reads 0 out of reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain consumer: credit-based FIFO read issue, skid buffering and a burst-marking valid/ready stream.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_BURST_LEN  = 4
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rden,
  input  logic [P_DATA_WIDTH-1:0] fifo_rdata,
  input  logic                    fifo_rddata_valid,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [P_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    err_protocol
);

  localparam int           BW        = beat_w(P_BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_BURST_LEN - 1);

  occ_t                    occ;
  logic [P_DATA_WIDTH-1:0] head;
  logic                    pop;
  logic [2:0]              credit;
  logic                    inflight_q;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    err_q, err_d;

  fifo_rd_skid_buf #(
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) u_buf (
    .clk    (rd_clk),
    .rst_n  (rd_rst_n),
    .push_i (fifo_rddata_valid),
    .pop_i  (pop),
    .wdata_i(fifo_rdata),
    .head_o (head),
    .occ_o  (occ)
  );

  assign m_valid = (occ != occ_t'(0));
  assign pop     = m_valid & m_ready;

  // Words held plus the word on its way, minus the one leaving: a read is only issued if its data will fit.
  assign credit    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rden = rd_rst_n & ~fifo_empty & (credit < 3'd2);

  always_comb begin
    beat_d = beat_q;
    if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    err_d = err_q | (fifo_rddata_valid & ~inflight_q);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_rden;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign m_data       = head;
  assign m_last       = m_valid & (beat_q == LAST_BEAT);
  assign err_protocol = err_q;

endmodule
